// File: rtl/alu_pkg.sv
// Shared constants for the lab ALU datapath arithmetic blocks.
package alu_pkg;

    localparam int unsigned ADDSUB_W = 2;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage : alu_pkg

// File: rtl/twos_compl_addsub_full_adder.sv
// Single-bit full adder, one stage of the add/subtract ripple chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Sum and carry of three single-bit inputs.
    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule : full_adder

// File: rtl/twos_compl_addsub.sv
// 2-bit two's-complement adder/subtractor with registered sum, carry,
// signed-overflow flag and result-valid strobe (latency 1 cycle).
module twos_compl_addsub
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] x,
    input  logic [1:0] y,
    input  logic       subc,
    input  logic       in_valid,
    output logic       s0,
    output logic       s1,
    output logic       c2,
    output logic       ovf,
    output logic       out_valid
);

    logic [ADDSUB_W-1:0] w_yb;
    logic                w_sub;
    logic                w_s0;
    logic                w_s1;
    logic                w_c1;
    logic                w_c2;
    logic                w_ovf;

    logic                r_s0;
    logic                r_s1;
    logic                r_c2;
    logic                r_ovf;
    logic                r_out_valid;

    // Subtract = add the ones' complement of y with subc as carry-in.
    always_comb begin
        w_sub = (subc == OP_SUB);
        w_yb  = y ^ {ADDSUB_W{w_sub}};
    end

    full_adder u_fa0 (
        .a    (x[0]),
        .b    (w_yb[0]),
        .cin  (w_sub),
        .s    (w_s0),
        .cout (w_c1)
    );

    full_adder u_fa1 (
        .a    (x[1]),
        .b    (w_yb[1]),
        .cin  (w_c1),
        .s    (w_s1),
        .cout (w_c2)
    );

    // Signed overflow: carry into the MSB differs from carry out of it.
    always_comb begin
        w_ovf = w_c1 ^ w_c2;
    end

    // Output registers: results captured only on valid input, strobe every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0        <= 1'b0;
            r_s1        <= 1'b0;
            r_c2        <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_s0  <= w_s0;
                r_s1  <= w_s1;
                r_c2  <= w_c2;
                r_ovf <= w_ovf;
            end
        end
    end

    assign s0        = r_s0;
    assign s1        = r_s1;
    assign c2        = r_c2;
    assign ovf       = r_ovf;
    assign out_valid = r_out_valid;

endmodule : twos_compl_addsub

// File: tb/tb_twos_compl_addsub.sv
// Directed and exhaustive checks for the 2-bit add/subtract block.
module tb_twos_compl_addsub;

    typedef struct {
        logic [1:0] x;
        logic [1:0] y;
        logic       subc;
        logic [1:0] exp_s;
        logic       exp_c2;
        logic       exp_ovf;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [1:0] x;
    logic [1:0] y;
    logic       subc;
    logic       in_valid;
    logic       s0;
    logic       s1;
    logic       c2;
    logic       ovf;
    logic       out_valid;

    int n_tests = 0;
    int n_fail  = 0;

    twos_compl_addsub dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .y         (y),
        .subc      (subc),
        .in_valid  (in_valid),
        .s0        (s0),
        .s1        (s1),
        .c2        (c2),
        .ovf       (ovf),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [1:0] got, input logic [1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Check all registered outputs against expected values.
    task automatic chk_all(input string tag, input logic [1:0] es, input logic ec2,
                           input logic eovf, input logic evld);
        chk({tag, ".sum"},       {s1, s0},          es);
        chk({tag, ".c2"},        {1'b0, c2},        {1'b0, ec2});
        chk({tag, ".ovf"},       {1'b0, ovf},       {1'b0, eovf});
        chk({tag, ".out_valid"}, {1'b0, out_valid}, {1'b0, evld});
    endtask

    // Independent reference: signed arithmetic for sum/overflow, unsigned for carry.
    function automatic vec_t model(input logic [1:0] a, input logic [1:0] b, input logic sub);
        vec_t v;
        int   sa, sb, r, u;
        sa = a[1] ? int'(a) - 4 : int'(a);
        sb = b[1] ? int'(b) - 4 : int'(b);
        r  = sub ? sa - sb : sa + sb;
        u  = sub ? int'(a) + (3 - int'(b)) + 1 : int'(a) + int'(b);
        v.x       = a;
        v.y       = b;
        v.subc    = sub;
        v.exp_s   = 2'(r & 3);
        v.exp_c2  = (u >= 4);
        v.exp_ovf = (r > 1) || (r < -2);
        return v;
    endfunction

    task automatic apply(input vec_t v);
        x        = v.x;
        y        = v.y;
        subc     = v.subc;
        in_valid = 1'b1;
    endtask

    vec_t tbl [10];
    vec_t last;

    initial begin
        tbl[0] = '{2'b11, 2'b00, 1'b0, 2'b11, 1'b0, 1'b0};
        tbl[1] = '{2'b11, 2'b11, 1'b0, 2'b10, 1'b1, 1'b0};
        tbl[2] = '{2'b11, 2'b11, 1'b1, 2'b00, 1'b1, 1'b0};
        tbl[3] = '{2'b01, 2'b01, 1'b0, 2'b10, 1'b0, 1'b1};
        tbl[4] = '{2'b10, 2'b01, 1'b1, 2'b01, 1'b1, 1'b1};
        tbl[5] = '{2'b00, 2'b01, 1'b1, 2'b11, 1'b0, 1'b0};
        tbl[6] = '{2'b01, 2'b00, 1'b1, 2'b01, 1'b1, 1'b0};
        tbl[7] = '{2'b00, 2'b10, 1'b1, 2'b10, 1'b0, 1'b1};
        tbl[8] = '{2'b01, 2'b10, 1'b1, 2'b11, 1'b0, 1'b1};
        tbl[9] = '{2'b10, 2'b10, 1'b0, 2'b00, 1'b1, 1'b1};

        // Reset with a valid operation present: it must be discarded.
        rst = 1'b1; x = 2'b11; y = 2'b11; subc = 1'b1; in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 2'b00, 1'b0, 1'b0, 1'b0);

        // Directed table; the first vector is captured on the first edge after release.
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            apply(tbl[i]);
            @(posedge clk); #1;
            chk_all($sformatf("tbl%0d", i), tbl[i].exp_s, tbl[i].exp_c2, tbl[i].exp_ovf, 1'b1);
        end

        // Idle gap: result held, strobe drops, then resumes.
        in_valid = 1'b0; x = 2'b00; y = 2'b00; subc = 1'b0;
        @(posedge clk); #1;
        chk_all("gap", tbl[9].exp_s, tbl[9].exp_c2, tbl[9].exp_ovf, 1'b0);
        apply(tbl[4]);
        @(posedge clk); #1;
        chk_all("resume", tbl[4].exp_s, tbl[4].exp_c2, tbl[4].exp_ovf, 1'b1);

        // Reset mid-stream wins over a valid overflowing add.
        rst = 1'b1; apply(tbl[3]);
        @(posedge clk); #1;
        chk_all("rst_prio", 2'b00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Exhaustive back-to-back sweep.
        for (int unsigned k = 0; k < 32; k++) begin
            last = model(2'(k >> 3), 2'(k >> 1), k[0]);
            apply(last);
            @(posedge clk); #1;
            chk_all($sformatf("sweep x=%b y=%b sub=%b", last.x, last.y, last.subc),
                    last.exp_s, last.exp_c2, last.exp_ovf, 1'b1);
        end

        // Drop valid and change operands: outputs hold the last result.
        in_valid = 1'b0; x = 2'b01; y = 2'b01; subc = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            chk_all($sformatf("hold%0d", j), last.exp_s, last.exp_c2, last.exp_ovf, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_twos_compl_addsub

// File: doc/twos_compl_addsub.md
Name: twos_compl_addsub

Overview:
- 2-bit two's-complement adder/subtractor with registered outputs.
- `subc`=0 computes x+y; `subc`=1 computes x−y by inverting y and injecting `subc` as carry-in.
- Exposes the sum bits individually (s0, s1), the raw carry-out (c2) and a signed-overflow flag.
- Leaf arithmetic block in the lab ALU datapath.

Parameters:
- None. Width is fixed at 2 bits; the port list (s0/s1/c2) is width-specific.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- x  input  2  operand A, two's complement
- y  input  2  operand B, two's complement
- subc  input  1  0 = add, 1 = subtract (also carry-in)
- in_valid  input  1  operands/subc valid this cycle
- s0  output  1  registered sum bit 0
- s1  output  1  registered sum bit 1
- c2  output  1  registered carry-out of bit 1 (for subtract: 1 = no borrow)
- ovf  output  1  registered signed overflow
- out_valid  output  1  registered result-valid strobe

Behaviour:
- Interface rule: one clock (`clk`); reset `rst` is synchronous and active-high.
- Datapath arithmetic (combinational):
  - yb = y XOR {subc,subc}
  - {c2,s1,s0} = x + yb + subc, a 3-bit result
  - Formed as a ripple chain: bit0 full adder (x[0], yb[0], cin=subc) → c1; bit1 full adder (x[1], yb[1], c1) → c2.
  - ovf = c1 XOR c2 (carry into MSB XOR carry out of MSB).
- Registering:
  - s0, s1, c2, ovf, out_valid are flops.
  - Latency is exactly 1 cycle: operands present at edge N appear on outputs after edge N.
  - out_valid <= in_valid every cycle.
- in_valid=0: s0/s1/c2/ovf hold their previous values; out_valid goes 0 next cycle.
- in_valid=1 on consecutive cycles: a new result every cycle (throughput 1/cycle); no backpressure.
- Reset:
  - When rst=1 at a clock edge: s0=s1=c2=ovf=out_valid=0, regardless of in_valid.
  - Reset takes priority over a simultaneous valid input; that operation is discarded.
  - Releasing reset: the first capture occurs at the first edge with rst=0.
- Wrap-around: results are taken modulo 4; the carry is not sign information. Signed correctness is indicated only by ovf.
- Subtract with y=00: yb=11, +1 → c2=1 and the sum equals x.
- Subtract with y=10 (−2): negation overflows internally but the arithmetic is unchanged; ovf follows the c1 XOR c2 rule.
- No X propagation allowed from reset state; all outputs are defined after the first reset edge.

Decomposition:
- Shared package (alu_pkg):
  - localparam ADDSUB_W = 2
  - opcode constants OP_ADD = 1'b0, OP_SUB = 1'b1
- One sub-module: full_adder (a, b, cin → s, cout), instantiated twice in the ripple chain.
- Top module holds the XOR inversion stage, the overflow logic and the output registers.

Test Plan:
- Reset: assert rst with x=11, y=11, subc=1, in_valid=1 for 2 cycles → s1s0=00, c2=0, ovf=0, out_valid=0.
- Add, no carry: x=11, y=00, subc=0, in_valid=1 → next cycle s1s0=11, c2=0, ovf=0, out_valid=1.
- Add with carry: x=11, y=11, subc=0 → s1s0=10, c2=1, ovf=0 (−1 + −1 = −2).
- Subtract: x=11, y=11, subc=1 → s1s0=00, c2=1, ovf=0.
- Overflow, one case per line:
  - Add x=01, y=01 → s1s0=10, c2=0, ovf=1.
  - Subtract x=10, y=01 → s1s0=01, c2=1, ovf=1.
  - Subtract x=00, y=01 → s1s0=11, c2=0 (borrow), ovf=0.
- Exhaustive plus hold:
  - Sweep all 32 combinations of x, y, subc back-to-back with in_valid=1; each output matches the 3-bit reference model one cycle later.
  - Then drop in_valid: outputs hold the last result and out_valid=0.
